// File: rtl/ldtu_fifo_pkg.sv
// Shared constants and helpers for the LiTe-DTU Hamming output FIFO.
//   NBITS_HAM       width of a Hamming-protected word (data + parity)
//   LDTU_IDLE_WORD  idle pattern driven on the read port after reset
//   ptr_level()     occupancy from a write/read pointer pair of width pw
package ldtu_fifo_pkg;

  localparam int unsigned NBITS_HAM      = 38;
  localparam logic [37:0] LDTU_IDLE_WORD = 38'h0040000000;

  // Pointers carry one extra wrap bit, so their modular difference is
  // the number of stored words (0..depth).
  function automatic logic [31:0] ptr_level(input logic [31:0] w,
                                            input logic [31:0] r,
                                            input int unsigned pw);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    return (w - r) & mask;
  endfunction

endpackage

// File: rtl/ldtu_fifo_regfile.sv
// Simple dual-port register array, 2**AW x NBITS, no reset.
//   CLK    clock, rising edge
//   we     write enable; wdata stored at waddr
//   re     read enable; rdata loads mem[raddr], otherwise holds
module ldtu_fifo_regfile #(
  parameter int unsigned NBITS = 38,
  parameter int unsigned AW    = 4
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NBITS-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [NBITS-1:0] rdata
);

  logic [(1<<AW)-1:0][NBITS-1:0] mem;

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ldtu_ham_ofifo_param.sv
// Output FIFO between the Hamming encoder and the serialiser/decoder path.
// All 2**DEPTH_LOG2 entries usable; registered read with one-cycle strobe.
//   CLK, rst        clock / synchronous active-high reset
//   flush           clears pointers and level, discards same-cycle requests
//   wr_en, wr_data  write port
//   rd_en           read request; rd_data/rd_valid valid the next cycle
//   empty, full, almost_full, level   occupancy status (registered state)
//   overflow, underflow               sticky errors, cleared by clr_err
module ldtu_ham_ofifo_param
  import ldtu_fifo_pkg::*;
#(
  parameter int unsigned      NBITS      = NBITS_HAM,
  parameter int unsigned      DEPTH_LOG2 = 4,
  parameter int unsigned      AFULL_THR  = 12,
  parameter logic [NBITS-1:0] RST_WORD   = NBITS'(LDTU_IDLE_WORD)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [NBITS-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [NBITS-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;

  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_q, level_nxt;
  logic             wr_acc, rd_acc;
  logic             data_ok;
  logic [NBITS-1:0] rf_q;

  // Status is purely a function of registered pointers/level.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                       (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign almost_full = (32'(level_q) >= AFULL_THR);
  assign level       = level_q;

  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  assign wr_nxt    = wr_ptr + PW'(wr_acc);
  assign rd_nxt    = rd_ptr + PW'(rd_acc);
  assign level_nxt = PW'(ptr_level(32'(wr_nxt), 32'(rd_nxt), PW));

  always_ff @(posedge CLK) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      rd_valid  <= 1'b0;
      data_ok   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      level_q   <= level_nxt;
      rd_valid  <= rd_acc;
      data_ok   <= data_ok | rd_acc;
      // A new error event beats a same-cycle clear.
      overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  // The array has no reset, so the idle word is muxed in until the first
  // read after reset loads the output register.
  assign rd_data = data_ok ? rf_q : RST_WORD;

  ldtu_fifo_regfile #(.NBITS(NBITS), .AW(DEPTH_LOG2)) u_rf (
    .CLK   (CLK),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr[PW-2:0]),
    .wdata (wr_data),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr[PW-2:0]),
    .rdata (rf_q)
  );

endmodule

// File: tb/tb_ldtu_ham_ofifo_param.sv
module tb_ldtu_ham_ofifo_param;

  localparam logic [37:0] IDLE = 38'h0040000000;

  logic        CLK = 1'b0;
  logic        rst, flush, wr_en, rd_en, clr_err;
  logic [37:0] wr_data, rd_data;
  logic        rd_valid, empty, full, almost_full, overflow, underflow;
  logic [4:0]  level;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  ldtu_ham_ofifo_param dut (
    .CLK(CLK), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  typedef struct {
    logic        rst, flush, wr, rd, clr;
    logic [37:0] wd;
    logic        e_rv;
    logic [37:0] e_rd;
    logic [4:0]  e_lvl;
    logic        e_emp, e_full, e_ovf, e_unf;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, sample 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic f, input logic w, input logic [37:0] wd,
                     input logic rd, input logic c);
    rst = r; flush = f; wr_en = w; wr_data = wd; rd_en = rd; clr_err = c;
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, 0, 0);
  endtask

  function automatic vec_t mk(input logic r, f, w, rd, c, input logic [37:0] wd,
                              input logic rv, input logic [37:0] erd, input logic [4:0] lv,
                              input logic em, fu, ov, un);
    vec_t v;
    v.rst = r; v.flush = f; v.wr = w; v.rd = rd; v.clr = c; v.wd = wd;
    v.e_rv = rv; v.e_rd = erd; v.e_lvl = lv; v.e_emp = em; v.e_full = fu;
    v.e_ovf = ov; v.e_unf = un;
    return v;
  endfunction

  initial begin
    //          rst f w r c  wdata        rv rd_data      lvl em fu ov un
    vt[0]  = mk(1, 0,0,0,0, 38'h0,       0, IDLE,        0, 1, 0, 0, 0);
    vt[1]  = mk(0, 0,0,0,0, 38'h0,       0, IDLE,        0, 1, 0, 0, 0);
    vt[2]  = mk(0, 0,0,1,0, 38'h0,       0, IDLE,        0, 1, 0, 0, 1);
    vt[3]  = mk(0, 0,0,1,1, 38'h0,       0, IDLE,        0, 1, 0, 0, 1);
    vt[4]  = mk(0, 0,0,0,1, 38'h0,       0, IDLE,        0, 1, 0, 0, 0);
    vt[5]  = mk(0, 0,1,1,0, 38'h2A5A5A5A5A, 0, IDLE,     1, 0, 0, 0, 1);
    vt[6]  = mk(0, 0,0,0,1, 38'h0,       0, IDLE,        1, 0, 0, 0, 0);
    vt[7]  = mk(0, 0,0,1,0, 38'h0,       1, 38'h2A5A5A5A5A, 0, 1, 0, 0, 0);
    vt[8]  = mk(0, 0,0,0,0, 38'h0,       0, 38'h2A5A5A5A5A, 0, 1, 0, 0, 0);
    vt[9]  = mk(0, 0,1,0,0, 38'h3FFFFFFFFF, 0, 38'h2A5A5A5A5A, 1, 0, 0, 0, 0);
    vt[10] = mk(0, 0,1,0,0, 38'h0000000123, 0, 38'h2A5A5A5A5A, 2, 0, 0, 0, 0);
    vt[11] = mk(0, 0,0,1,0, 38'h0,       1, 38'h3FFFFFFFFF, 1, 0, 0, 0, 0);
    vt[12] = mk(1, 0,0,0,0, 38'h0,       0, IDLE,        0, 1, 0, 0, 0);

    cyc(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].rst, vt[i].flush, vt[i].wr, vt[i].wd, vt[i].rd, vt[i].clr);
      chk($sformatf("v%0d.rd_valid", i), 64'(rd_valid),  64'(vt[i].e_rv));
      chk($sformatf("v%0d.rd_data", i),  64'(rd_data),   64'(vt[i].e_rd));
      chk($sformatf("v%0d.level", i),    64'(level),     64'(vt[i].e_lvl));
      chk($sformatf("v%0d.empty", i),    64'(empty),     64'(vt[i].e_emp));
      chk($sformatf("v%0d.full", i),     64'(full),      64'(vt[i].e_full));
      chk($sformatf("v%0d.overflow", i), 64'(overflow),  64'(vt[i].e_ovf));
      chk($sformatf("v%0d.underflow", i),64'(underflow), 64'(vt[i].e_unf));
    end

    // Fill to full, overflow, then simultaneous access at full and drain.
    cyc(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 38'(i), 0, 0);
      chk($sformatf("fill%0d.level", i), 64'(level), 64'(i + 1));
      chk($sformatf("fill%0d.afull", i), 64'(almost_full), 64'((i + 1) >= 12));
      chk($sformatf("fill%0d.full", i),  64'(full), 64'((i + 1) == 16));
    end
    cyc(0, 0, 1, 38'h77, 0, 0);
    chk("ovf.flag", 64'(overflow), 64'd1);
    chk("ovf.level", 64'(level), 64'd16);
    cyc(0, 0, 0, '0, 0, 1);
    chk("ovf.clr", 64'(overflow), 64'd0);
    cyc(0, 0, 1, 38'h99, 1, 0);
    chk("wrrd_full.ovf", 64'(overflow), 64'd1);
    chk("wrrd_full.level", 64'(level), 64'd15);
    chk("wrrd_full.rv", 64'(rd_valid), 64'd1);
    chk("wrrd_full.data", 64'(rd_data), 64'd0);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 0, '0, 1, 0);
      chk($sformatf("drain%0d.rv", i), 64'(rd_valid), 64'd1);
      chk($sformatf("drain%0d.data", i), 64'(rd_data), 64'(i));
    end
    idle();
    chk("drain.empty", 64'(empty), 64'd1);
    chk("drain.rv", 64'(rd_valid), 64'd0);
    chk("drain.hold", 64'(rd_data), 64'd15);

    // Pointer wrap with a steady 3-word backlog.
    cyc(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 38'(100 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0, 1, 38'(103 + i), 1, 0);
      chk($sformatf("wrap%0d.data", i), 64'(rd_data), 64'(100 + i));
      chk($sformatf("wrap%0d.rv", i), 64'(rd_valid), 64'd1);
      chk($sformatf("wrap%0d.level", i), 64'(level), 64'd3);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, '0, 1, 0);
      chk($sformatf("wrapd%0d.data", i), 64'(rd_data), 64'(140 + i));
    end
    idle();
    chk("wrap.empty", 64'(empty), 64'd1);
    chk("wrap.unf", 64'(underflow), 64'd0);

    // Flush at level 5 with both requests active.
    cyc(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 38'(200 + i), 0, 0);
    cyc(0, 0, 0, '0, 1, 0);
    chk("pre_flush.level", 64'(level), 64'd5);
    chk("pre_flush.rv", 64'(rd_valid), 64'd1);
    cyc(0, 1, 1, 38'h55, 1, 0);
    chk("flush.level", 64'(level), 64'd0);
    chk("flush.empty", 64'(empty), 64'd1);
    chk("flush.rv", 64'(rd_valid), 64'd0);
    chk("flush.ovf", 64'(overflow), 64'd0);
    chk("flush.unf", 64'(underflow), 64'd0);
    chk("flush.data", 64'(rd_data), 64'd200);
    cyc(0, 0, 1, 38'h1234, 0, 0);
    cyc(0, 0, 0, '0, 1, 0);
    chk("post_flush.data", 64'(rd_data), 64'h1234);
    chk("post_flush.empty", 64'(empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
